mem_access: RTL and testbench

MEM-stage data-bus master of the five-stage pipeline. Sits directly after the EX/MEM pipeline register and consumes its memory-related outputs: operation code, effective address, store data and the ALU result. It decodes load/store operations, checks alignment and drives a single-outstanding req/ack data-bus transaction. It stalls the pipeline until the access completes, then presents the extended load data, or the passed-through ALU result, to MEM/WB.

---
 rtl/mem_access.sv | 193 +++++++++++++++++++
 tb/tb_mem_access.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage data-bus master: decodes load/store ops, checks alignment and runs
// a single-outstanding req/ack transaction, stalling the pipeline until done.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        advance,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] mem_wdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [31:0] result,
    output logic        stallreq,
    output logic        except_adel,
    output logic        except_ades,
    output logic [31:0] badvaddr
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        load_q, load_d;
    size_e       size_q, size_d;
    logic        zext_q, zext_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_load, is_store, zext, misaligned, mem_op_ok;
    size_e       size;
    logic [1:0]  lane;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] ln,
                                           input size_e sz, input logic zx);
        logic [31:0] sh;
        logic [31:0] r;
        sh = d >> {ln, 3'b000};
        case (sz)
            SZ_B:    r = zx ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    r = zx ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign lane = mem_mem_addr[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SZ_B;
        zext     = 1'b0;
        case (mem_aluop)
            EXE_LB_OP:  is_load = 1'b1;
            EXE_LBU_OP: begin is_load = 1'b1; zext = 1'b1; end
            EXE_LH_OP:  begin is_load = 1'b1; size = SZ_H; end
            EXE_LHU_OP: begin is_load = 1'b1; size = SZ_H; zext = 1'b1; end
            EXE_LW_OP:  begin is_load = 1'b1; size = SZ_W; end
            EXE_SB_OP:  is_store = 1'b1;
            EXE_SH_OP:  begin is_store = 1'b1; size = SZ_H; end
            EXE_SW_OP:  begin is_store = 1'b1; size = SZ_W; end
            default:    ;
        endcase

        misaligned = ((size == SZ_H) && lane[0]) || ((size == SZ_W) && (lane != 2'b00));

        case (size)
            SZ_B: begin
                be_c    = 4'b0001 << lane;
                wdata_c = {4{mem_reg2[7:0]}};
            end
            SZ_H: begin
                be_c    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{mem_reg2[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = mem_reg2;
            end
        endcase

        mem_op_ok = (is_load || is_store) && !misaligned;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        size_d  = size_q;
        zext_d  = zext_q;
        lane_d  = lane_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_op_ok && !flush) begin
                    state_d = WAIT;
                    we_d    = is_store;
                    addr_d  = {mem_mem_addr[31:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    load_d  = is_load;
                    size_d  = size;
                    zext_d  = zext;
                    lane_d  = lane;
                end
            end
            WAIT: begin
                // A flush coinciding with ack completes the transfer but drops its data.
                if (dbus_ack) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        rdata_d = extend(dbus_rdata, lane_q, size_q, zext_q);
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (advance || flush) state_d = IDLE;
            end
            DRAIN: begin
                if (dbus_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            size_q  <= SZ_B;
            zext_q  <= 1'b0;
            lane_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            size_q  <= size_d;
            zext_q  <= zext_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
        end
    end

    assign dbus_req    = (state_q == WAIT) || (state_q == DRAIN);
    assign dbus_we     = we_q;
    assign dbus_addr   = addr_q;
    assign dbus_be     = be_q;
    assign dbus_wdata  = wdata_q;
    assign result      = ((state_q == HOLD) && load_q) ? rdata_q : mem_wdata;
    assign stallreq    = rst && (((state_q == IDLE) && mem_op_ok && !flush) ||
                                 (state_q == WAIT) || (state_q == DRAIN));
    assign except_adel = is_load && misaligned;
    assign except_ades = is_store && misaligned;
    assign badvaddr    = mem_mem_addr;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scoreboarded load/store results, bus field
// checks, alignment exceptions, flush drain and asynchronous reset.
module tb_mem_access;

    localparam logic [7:0] NOP_OP     = 8'h00;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [31:0] ALU_VAL   = 32'hA1A1_0001;

    logic        clk = 1'b0;
    logic        rst, flush, advance;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2, mem_wdata;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic [31:0] result, badvaddr;
    logic        stallreq, except_adel, except_ades;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .flush(flush), .advance(advance),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .mem_wdata(mem_wdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
        .dbus_ack(dbus_ack), .result(result), .stallreq(stallreq),
        .except_adel(except_adel), .except_ades(except_ades), .badvaddr(badvaddr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_nop(input logic [31:0] alu);
        @(posedge clk); #1;
        advance = 1'b0; flush = 1'b0; mem_aluop = NOP_OP; mem_wdata = alu;
        @(negedge clk);
        check("nop_result", result, alu);
        check("nop_stall", stallreq, 1'b0);
        check("nop_req", dbus_req, 1'b0);
    endtask

    task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rdata, input int unsigned waits, input int unsigned hold,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_res);
        logic        st;
        logic [31:0] exp;
        st = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
        sb_q.push_back(exp_res);
        @(posedge clk); #1;
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2; mem_wdata = ALU_VAL;
        advance = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_stall", stallreq, 1'b1);
        check("idle_req", dbus_req, 1'b0);
        for (int unsigned w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            dbus_ack   = (w == waits);
            dbus_rdata = (w == waits) ? rdata : $urandom;
            @(negedge clk);
            check("wait_req", dbus_req, 1'b1);
            check("wait_stall", stallreq, 1'b1);
            check("bus_addr", dbus_addr, {addr[31:2], 2'b00});
            check("bus_be", {28'd0, dbus_be}, {28'd0, exp_be});
            check("bus_we", dbus_we, st);
            if (st) check("bus_wdata", dbus_wdata, exp_wdata);
        end
        @(posedge clk); #1;
        dbus_ack = 1'b0; dbus_rdata = $urandom; advance = (hold == 0);
        @(negedge clk);
        exp = sb_q.pop_front();
        check("result", result, exp);
        check("hold_stall", stallreq, 1'b0);
        check("hold_req", dbus_req, 1'b0);
        for (int unsigned h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            dbus_ack = (h == 2);  // stray ack in HOLD must be ignored
            advance = (h == hold);
            @(negedge clk);
            check("hold_result", result, exp);
            check("hold_req2", dbus_req, 1'b0);
            check("hold_stall2", stallreq, 1'b0);
        end
        dbus_ack = 1'b0;
        idle_nop(32'h5555_0000 + addr);
    endtask

    task automatic misaligned(input logic [7:0] op, input logic [31:0] addr,
                              input logic exp_adel, input logic exp_ades);
        @(posedge clk); #1;
        mem_aluop = op; mem_mem_addr = addr; mem_wdata = ALU_VAL; advance = 1'b0;
        @(negedge clk);
        check("adel", except_adel, exp_adel);
        check("ades", except_ades, exp_ades);
        check("badvaddr", badvaddr, addr);
        check("mis_stall", stallreq, 1'b0);
        check("mis_result", result, ALU_VAL);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_req", dbus_req, 1'b0);
        idle_nop(32'h0BAD_0000);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; advance = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
        mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h0000_1000; mem_reg2 = 32'hFFFF_FFFF;
        mem_wdata = 32'h0000_1234;
        #12;
        check("rst_req", dbus_req, 1'b0);
        check("rst_we", dbus_we, 1'b0);
        check("rst_addr", dbus_addr, 32'h0);
        check("rst_be", {28'd0, dbus_be}, 32'h0);
        check("rst_wdata", dbus_wdata, 32'h0);
        check("rst_stall", stallreq, 1'b0);
        check("rst_result", result, 32'h0000_1234);
        mem_aluop = NOP_OP;
        @(negedge clk); rst = 1'b1;

        access(EXE_SW_OP,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0,          2, 0, 4'b1111, 32'hDEAD_BEEF, ALU_VAL);
        access(EXE_LB_OP,  32'h0000_2003, 32'h0,         32'h8012_3456,  0, 0, 4'b1000, 32'h0,         32'hFFFF_FF80);
        access(EXE_LBU_OP, 32'h0000_2003, 32'h0,         32'h8012_3456,  1, 0, 4'b1000, 32'h0,         32'h0000_0080);
        access(EXE_LH_OP,  32'h0000_2002, 32'h0,         32'h8001_7FFF,  0, 0, 4'b1100, 32'h0,         32'hFFFF_8001);
        access(EXE_LHU_OP, 32'h0000_2002, 32'h0,         32'h8001_7FFF,  0, 0, 4'b1100, 32'h0,         32'h0000_8001);
        access(EXE_LB_OP,  32'h0000_3001, 32'h0,         32'h0000_7F00,  0, 0, 4'b0010, 32'h0,         32'h0000_007F);
        access(EXE_LHU_OP, 32'h0000_3000, 32'h0,         32'hFFFF_1234,  1, 0, 4'b0011, 32'h0,         32'h0000_1234);
        access(EXE_SB_OP,  32'h0000_4002, 32'h1234_56AB, 32'h0,          0, 0, 4'b0100, 32'hABAB_ABAB, ALU_VAL);
        access(EXE_SH_OP,  32'h0000_4000, 32'h0000_BEEF, 32'h0,          0, 0, 4'b0011, 32'hBEEF_BEEF, ALU_VAL);

        misaligned(EXE_LW_OP, 32'h0000_1002, 1'b1, 1'b0);
        misaligned(EXE_SH_OP, 32'h0000_4001, 1'b0, 1'b1);
        misaligned(EXE_LH_OP, 32'h0000_2003, 1'b1, 1'b0);
        misaligned(EXE_SW_OP, 32'h0000_4002, 1'b0, 1'b1);

        // flush in IDLE suppresses the request
        @(posedge clk); #1;
        mem_aluop = EXE_SW_OP; mem_mem_addr = 32'h0000_5000; flush = 1'b1;
        @(negedge clk);
        check("iflush_stall", stallreq, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; mem_aluop = NOP_OP;
        @(negedge clk);
        check("iflush_req", dbus_req, 1'b0);

        // flush in WAIT drains the outstanding request
        @(posedge clk); #1;
        mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h0000_6000; mem_wdata = ALU_VAL;
        @(negedge clk);
        check("fl_idle_stall", stallreq, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_wait_req", dbus_req, 1'b1);
        check("fl_wait_stall", stallreq, 1'b1);
        for (int unsigned c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            flush = 1'b0; mem_aluop = NOP_OP; mem_wdata = 32'h0000_0F0F;
            dbus_ack = (c == 3); dbus_rdata = 32'hCAFE_F00D;
            @(negedge clk);
            check("drain_req", dbus_req, 1'b1);
            check("drain_stall", stallreq, 1'b1);
        end
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("drain_done_req", dbus_req, 1'b0);
        check("drain_done_stall", stallreq, 1'b0);
        check("drain_no_capture", result, 32'h0000_0F0F);

        access(EXE_LW_OP, 32'h0000_2000, 32'h0, 32'h1234_5678, 0, 5, 4'b1111, 32'h0, 32'h1234_5678);

        // asynchronous reset while in WAIT
        @(posedge clk); #1;
        mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h0000_7000;
        @(posedge clk); #1;
        mem_aluop = NOP_OP;
        @(negedge clk);
        check("ar_req_before", dbus_req, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("ar_req", dbus_req, 1'b0);
        check("ar_stall", stallreq, 1'b0);
        check("ar_addr", dbus_addr, 32'h0);
        @(negedge clk); rst = 1'b1;
        access(EXE_SB_OP, 32'h0000_7003, 32'h0000_0011, 32'h0, 0, 0, 4'b1000, 32'h1111_1111, ALU_VAL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
